store_drain_buffer: RTL and testbench

Post-commit store buffer in the LSU, directly downstream of the store data queue. It accepts one architecturally committed store per cycle: word address, data and byte enables. It holds each store in a FIFO and drains the stores in order to the data-cache write port with a valid/ready request and a response ack. Younger loads can search it combinationally so that committed-but-undrained bytes are forwarded.

---
 rtl/store_drain_buffer_pkg.sv | 32 +++
 rtl/store_drain_buffer_fwd_select.sv | 42 ++++
 rtl/store_drain_buffer.sv | 140 ++++++++++++++
 tb/tb_store_drain_buffer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_drain_buffer_pkg.sv
// Shared types for the post-commit store drain buffer.
// Entry layout, drain FSM encoding and the byte-merge helper used when SDB_COALESCE_EN is defined.
package store_drain_buffer_pkg;

    localparam int SDB_ENTRIES = 8;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } sdb_entry_t;

    typedef enum logic [1:0] {
        SDB_IDLE = 2'd0,
        SDB_REQ  = 2'd1,
        SDB_WAIT = 2'd2
    } sdb_state_t;

    // Overlay the enabled lanes of a new store onto an existing entry.
    function automatic sdb_entry_t sdb_merge(input sdb_entry_t ent,
                                             input logic [31:0] data,
                                             input logic [3:0]  be);
        sdb_entry_t res;
        res = ent;
        for (int l = 0; l < 4; l++) begin
            res.data[l*8 +: 8] = be[l] ? data[l*8 +: 8] : ent.data[l*8 +: 8];
        end
        res.be = ent.be | be;
        return res;
    endfunction

endpackage

// File: rtl/store_drain_buffer_fwd_select.sv
// Per-lane youngest-match forwarding selector over the store drain buffer entries.
// Walks the live window oldest to youngest so that younger hits overwrite older ones.
module sdb_fwd_select
    import store_drain_buffer_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  sdb_entry_t [ENTRIES-1:0]      entries,
    input  logic [$clog2(ENTRIES)-1:0]    head,
    input  logic [$clog2(ENTRIES):0]      count,
    input  logic [29:0]                   waddr,
    output logic [3:0]                    fwd_be,
    output logic [31:0]                   fwd_data
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int PTR_W = IDX_W + 1;

    logic [IDX_W-1:0] sel_idx_s;
    logic             live_s;
    logic             hit_s;

    // Age-ordered scan of the occupied slots; the in-flight head stays in the window until it pops.
    always_comb begin
        fwd_be    = 4'b0;
        fwd_data  = 32'h0;
        sel_idx_s = '0;
        live_s    = 1'b0;
        hit_s     = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            sel_idx_s = head + IDX_W'(i);
            live_s    = (PTR_W'(i) < count) && (entries[sel_idx_s].waddr == waddr);
            for (int l = 0; l < 4; l++) begin
                hit_s              = live_s && entries[sel_idx_s].be[l];
                fwd_be[l]          = fwd_be[l] | hit_s;
                fwd_data[l*8 +: 8] = hit_s ? entries[sel_idx_s].data[l*8 +: 8]
                                           : fwd_data[l*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/store_drain_buffer.sv
// Post-commit store buffer: FIFO of committed stores drained in order to the D-cache write port.
// Optional feature macro: SDB_COALESCE_EN (merge a commit into the youngest entry on word match).
module store_drain_buffer #(
    parameter int SDB_ENTRIES = store_drain_buffer_pkg::SDB_ENTRIES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmit_vld,
    input  logic [31:0] cmit_addr,
    input  logic [31:0] cmit_data,
    input  logic [3:0]  cmit_be,
    output logic        cmit_rdy,
    output logic        mem_req_vld,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_be,
    input  logic        mem_req_rdy,
    input  logic        mem_resp_vld,
    input  logic [31:0] fwd_addr,
    output logic [3:0]  fwd_be,
    output logic [31:0] fwd_data,
    output logic        sdb_empty
);

    import store_drain_buffer_pkg::*;

    localparam int IDX_W = $clog2(SDB_ENTRIES);
    localparam int PTR_W = IDX_W + 1;

    sdb_entry_t [SDB_ENTRIES-1:0] entries_r;
    logic [PTR_W-1:0]             head_r;
    logic [PTR_W-1:0]             tail_r;
    sdb_state_t                   state_r;
    sdb_state_t                   state_nxt;

    logic [IDX_W-1:0] head_idx_s;
    logic [IDX_W-1:0] tail_idx_s;
    logic [PTR_W-1:0] count_s;
    logic             full_s;
    logic             empty_s;
    logic             accept_s;
    logic             merge_s;
    logic             push_s;
    logic             pop_s;
    logic             req_active_s;
    sdb_entry_t       head_ent_s;
    sdb_entry_t       new_ent_s;
    logic             unused_addr_lsbs;

    assign head_idx_s = head_r[IDX_W-1:0];
    assign tail_idx_s = tail_r[IDX_W-1:0];
    assign count_s    = tail_r - head_r;
    assign full_s     = (head_r[IDX_W] != tail_r[IDX_W]) && (head_idx_s == tail_idx_s);
    assign empty_s    = (head_r == tail_r);

    // No push-when-full even if the head pops this edge: ready depends on the pointers only.
    assign cmit_rdy  = !full_s;
    assign accept_s  = cmit_vld && !full_s;
    assign new_ent_s = '{waddr: cmit_addr[31:2], data: cmit_data, be: cmit_be};
    assign unused_addr_lsbs = ^{cmit_addr[1:0], fwd_addr[1:0]};

`ifdef SDB_COALESCE_EN
    logic [IDX_W-1:0] young_idx_s;
    logic             young_busy_s;

    assign young_idx_s  = tail_idx_s - IDX_W'(1);
    // The youngest entry is frozen once it is the head being drained.
    assign young_busy_s = (count_s == PTR_W'(1)) && (state_r != SDB_IDLE);
    assign merge_s      = accept_s && !empty_s && !young_busy_s &&
                          (entries_r[young_idx_s].waddr == cmit_addr[31:2]);
`else
    assign merge_s = 1'b0;
`endif

    assign push_s = accept_s && !merge_s;
    assign pop_s  = (state_r == SDB_WAIT) && mem_resp_vld;

    // Entry storage and FIFO pointers; push and pop in the same edge both apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_r <= '0;
            head_r    <= '0;
            tail_r    <= '0;
        end else begin
            if (push_s) begin
                entries_r[tail_idx_s] <= new_ent_s;
                tail_r                <= tail_r + PTR_W'(1);
            end
`ifdef SDB_COALESCE_EN
            if (merge_s) begin
                entries_r[young_idx_s] <= sdb_merge(entries_r[young_idx_s], cmit_data, cmit_be);
            end
`endif
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SDB_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Drain FSM next-state: one request and one ack per store, acks outside WAIT are ignored.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            SDB_IDLE: state_nxt = empty_s      ? SDB_IDLE : SDB_REQ;
            SDB_REQ:  state_nxt = mem_req_rdy  ? SDB_WAIT : SDB_REQ;
            SDB_WAIT: state_nxt = mem_resp_vld ? SDB_IDLE : SDB_WAIT;
            default:  state_nxt = SDB_IDLE;
        endcase
    end

    // Head cannot change while in REQ, so the request fields stay stable under backpressure.
    assign head_ent_s   = entries_r[head_idx_s];
    assign req_active_s = (state_r == SDB_REQ);
    assign mem_req_vld  = req_active_s;
    assign mem_req_addr = req_active_s ? {head_ent_s.waddr, 2'b00} : 32'h0;
    assign mem_req_data = req_active_s ? head_ent_s.data : 32'h0;
    assign mem_req_be   = req_active_s ? head_ent_s.be   : 4'b0;
    assign sdb_empty    = empty_s && (state_r == SDB_IDLE);

    sdb_fwd_select #(
        .ENTRIES (SDB_ENTRIES)
    ) u_fwd_select (
        .entries  (entries_r),
        .head     (head_idx_s),
        .count    (count_s),
        .waddr    (fwd_addr[31:2]),
        .fwd_be   (fwd_be),
        .fwd_data (fwd_data)
    );

endmodule

// File: tb/tb_store_drain_buffer.sv
// Self-checking bench for store_drain_buffer: directed table, hand sequences and a random run
// against a queue-based model of committed-but-undrained stores.
module tb_store_drain_buffer;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmit_vld;
    logic [31:0] cmit_addr;
    logic [31:0] cmit_data;
    logic [3:0]  cmit_be;
    logic        cmit_rdy;
    logic        mem_req_vld;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_be;
    logic        mem_req_rdy;
    logic        mem_resp_vld;
    logic [31:0] fwd_addr;
    logic [3:0]  fwd_be;
    logic [31:0] fwd_data;
    logic        sdb_empty;

    always #5 clk = ~clk;

    store_drain_buffer #(.SDB_ENTRIES(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmit_vld     (cmit_vld),
        .cmit_addr    (cmit_addr),
        .cmit_data    (cmit_data),
        .cmit_be      (cmit_be),
        .cmit_rdy     (cmit_rdy),
        .mem_req_vld  (mem_req_vld),
        .mem_req_addr (mem_req_addr),
        .mem_req_data (mem_req_data),
        .mem_req_be   (mem_req_be),
        .mem_req_rdy  (mem_req_rdy),
        .mem_resp_vld (mem_resp_vld),
        .fwd_addr     (fwd_addr),
        .fwd_be       (fwd_be),
        .fwd_data     (fwd_data),
        .sdb_empty    (sdb_empty)
    );

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } ment_t;

    typedef struct packed {
        logic        cv;
        logic [31:0] ca;
        logic [31:0] cd;
        logic [3:0]  cb;
        logic        rdy;
        logic        resp;
        logic [31:0] fa;
        logic        e_crdy;
        logic        e_vld;
        logic [31:0] e_addr;
        logic [3:0]  e_fbe;
        logic [31:0] e_fdata;
        logic        e_empty;
    } vec_t;

    vec_t  vecs [10];
    ment_t mq[$];
    ment_t got_q[$];
    bit    outstanding = 1'b0;
    int    wr_count = 0;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_fwd(input logic [31:0] a, output logic [3:0] be,
                                      output logic [31:0] d);
        be = 4'b0;
        d  = 32'h0;
        foreach (mq[i]) begin
            if (mq[i].waddr == a[31:2]) begin
                for (int l = 0; l < 4; l++) begin
                    if (mq[i].be[l]) begin
                        be[l]        = 1'b1;
                        d[l*8 +: 8]  = mq[i].data[l*8 +: 8];
                    end
                end
            end
        end
    endfunction

    // Check every visible output against the model, advance the model across the edge, clock.
    task automatic cycle();
        logic [3:0]  ebe;
        logic [31:0] ed;
        bit          acc;
        bit          merge;
        bit          hs;
        bit          pop;
        ment_t       t;
        #1;
        model_fwd(fwd_addr, ebe, ed);
        chk("cmit_rdy", cmit_rdy, mq.size() < N);
        chk("sdb_empty", sdb_empty, mq.size() == 0);
        chk("fwd_be", fwd_be, ebe);
        chk("fwd_data", fwd_data, ed);
        if (mem_req_vld) begin
            if (mq.size() == 0 || outstanding) begin
                checks++;
                errors++;
                $display("FAIL mem_req_vld: got 1 expected 0");
            end else begin
                chk("mem_req_addr", mem_req_addr, {mq[0].waddr, 2'b00});
                chk("mem_req_data", mem_req_data, mq[0].data);
                chk("mem_req_be", mem_req_be, mq[0].be);
            end
        end
        acc   = cmit_vld && (mq.size() < N);
        merge = 1'b0;
`ifdef SDB_COALESCE_EN
        if (acc && mq.size() > 0) begin
            merge = (mq[mq.size()-1].waddr == cmit_addr[31:2]) &&
                    !(mq.size() == 1 && (outstanding || mem_req_vld));
        end
`endif
        hs  = mem_req_vld && mem_req_rdy;
        pop = outstanding && mem_resp_vld;
        if (hs) got_q.push_back('{mem_req_addr[31:2], mem_req_data, mem_req_be});
        if (merge) begin
            t = mq[mq.size()-1];
            for (int l = 0; l < 4; l++) begin
                if (cmit_be[l]) t.data[l*8 +: 8] = cmit_data[l*8 +: 8];
            end
            t.be = t.be | cmit_be;
            mq[mq.size()-1] = t;
        end
        if (pop) begin
            void'(mq.pop_front());
            wr_count++;
        end
        if (acc && !merge) mq.push_back('{cmit_addr[31:2], cmit_data, cmit_be});
        outstanding = hs ? 1'b1 : (pop ? 1'b0 : outstanding);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        cmit_vld = 1'b0;
        while ((mq.size() > 0 || outstanding) && n < budget) begin
            mem_req_rdy  = 1'b1;
            mem_resp_vld = outstanding;
            cycle();
            n++;
        end
        mem_req_rdy  = 1'b0;
        mem_resp_vld = 1'b0;
        chk("drain_done", (mq.size() == 0 && !outstanding), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        //            cv    ca           cd           cb    rdy   resp  fa          crdy  vld   addr         fbe   fdata        empty
        vecs[0] = '{1'b0, 32'h0,      32'h0,        4'h0, 1'b0, 1'b0, 32'h1000, 1'b1, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1};
        vecs[1] = '{1'b1, 32'h1000,   32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h1000, 1'b1, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1};
        vecs[2] = '{1'b0, 32'h0,      32'h0,        4'h0, 1'b1, 1'b0, 32'h1000, 1'b1, 1'b0, 32'h0,    4'hF, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b0, 32'h0,      32'h0,        4'h0, 1'b1, 1'b0, 32'h1000, 1'b1, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b0};
        vecs[4] = '{1'b0, 32'h0,      32'h0,        4'h0, 1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h0,    4'hF, 32'hDEADBEEF, 1'b0};
        vecs[5] = '{1'b0, 32'h0,      32'h0,        4'h0, 1'b0, 1'b0, 32'h1000, 1'b1, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1};
        vecs[6] = '{1'b1, 32'h2000,   32'h000000AA, 4'h3, 1'b0, 1'b0, 32'h2002, 1'b1, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1};
        vecs[7] = '{1'b1, 32'h2000,   32'h000000BB, 4'h1, 1'b0, 1'b0, 32'h2002, 1'b1, 1'b0, 32'h0,    4'h3, 32'h000000AA, 1'b0};
        vecs[8] = '{1'b0, 32'h0,      32'h0,        4'h0, 1'b0, 1'b0, 32'h2002, 1'b1, 1'b1, 32'h2000, 4'h3, 32'h000000BB, 1'b0};
        vecs[9] = '{1'b0, 32'h0,      32'h0,        4'h0, 1'b0, 1'b0, 32'h2004, 1'b1, 1'b1, 32'h2000, 4'h0, 32'h0,        1'b0};

        rst          = 1'b1;
        cmit_vld     = 1'b0;
        cmit_addr    = 32'h0;
        cmit_data    = 32'h0;
        cmit_be      = 4'h0;
        mem_req_rdy  = 1'b0;
        mem_resp_vld = 1'b0;
        fwd_addr     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset cmit_rdy", cmit_rdy, 1);
        chk("reset sdb_empty", sdb_empty, 1);
        chk("reset mem_req_vld", mem_req_vld, 0);
        chk("reset mem_req_addr", mem_req_addr, 32'h0);
        chk("reset fwd_be", fwd_be, 0);
        chk("reset fwd_data", fwd_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed timing/forwarding table, one row per cycle.
        for (int i = 0; i < 10; i++) begin
            cmit_vld     = vecs[i].cv;
            cmit_addr    = vecs[i].ca;
            cmit_data    = vecs[i].cd;
            cmit_be      = vecs[i].cb;
            mem_req_rdy  = vecs[i].rdy;
            mem_resp_vld = vecs[i].resp;
            fwd_addr     = vecs[i].fa;
            #1;
            chk($sformatf("vec%0d cmit_rdy", i), cmit_rdy, vecs[i].e_crdy);
            chk($sformatf("vec%0d mem_req_vld", i), mem_req_vld, vecs[i].e_vld);
            chk($sformatf("vec%0d mem_req_addr", i), mem_req_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d fwd_be", i), fwd_be, vecs[i].e_fbe);
            chk($sformatf("vec%0d fwd_data", i), fwd_data, vecs[i].e_fdata);
            chk($sformatf("vec%0d sdb_empty", i), sdb_empty, vecs[i].e_empty);
            cycle();
        end
        drain(100);

        // Fill all entries against a stalled cache, refuse a 9th, then drain in order.
        got_q.delete();
        mem_req_rdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            cmit_vld  = 1'b1;
            cmit_addr = 32'h5000 + 32'(4 * i);
            cmit_data = $urandom;
            cmit_be   = 4'hF;
            cycle();
        end
        cmit_vld  = 1'b1;
        cmit_addr = 32'h6000;
        #1;
        chk("full cmit_rdy", cmit_rdy, 0);
        cycle();
        cmit_vld = 1'b0;
        repeat (3) cycle();
        drain(100);
        chk("full drain count", got_q.size(), N);
        for (int i = 0; i < N && i < got_q.size(); i++) begin
            chk($sformatf("full order %0d", i), {got_q[i].waddr, 2'b00}, 32'h5000 + 32'(4 * i));
        end
        #1;
        chk("cmit_rdy after drain", cmit_rdy, 1);

        // Random commits, stalls and spurious acks across many pointer wraps.
        w0 = wr_count;
        for (int c = 0; c < 400; c++) begin
            cmit_vld     = ($urandom_range(0, 2) != 0);
            cmit_addr    = 32'h100 + 32'(4 * $urandom_range(0, 3));
            cmit_data    = $urandom;
            cmit_be      = 4'($urandom_range(1, 15));
            mem_req_rdy  = ($urandom_range(0, 2) == 0);
            mem_resp_vld = outstanding ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            fwd_addr     = 32'h100 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
            cycle();
        end
        drain(200);
        chk("random writes >= 20", (wr_count - w0) >= 20, 1);

`ifdef SDB_COALESCE_EN
        // Merge behind an older entry that is stalled in REQ.
        got_q.delete();
        mem_req_rdy = 1'b0;
        cmit_vld    = 1'b1;
        cmit_addr   = 32'h4000;
        cmit_data   = 32'h11223344;
        cmit_be     = 4'hF;
        cycle();
        cmit_vld = 1'b0;
        cycle();
        chk("coal older in REQ", mem_req_vld, 1);
        cmit_vld  = 1'b1;
        cmit_addr = 32'h3000;
        cmit_data = 32'h000000A1;
        cmit_be   = 4'h1;
        cycle();
        cmit_data = 32'h0000B200;
        cmit_be   = 4'h2;
        cycle();
        cmit_vld = 1'b0;
        drain(100);
        chk("coal write count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("coal addr", {got_q[1].waddr, 2'b00}, 32'h3000);
            chk("coal be", got_q[1].be, 4'h3);
            chk("coal data", got_q[1].data, 32'h0000B2A1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
